// File: rtl/sdram_client_pkg.sv
// Shared types for the SDRAM port client: FSM states and the queued request word.
package sdram_client_pkg;

  localparam int REQ_ADDR_W = 25;
  localparam int REQ_DATA_W = 16;
  localparam int REQ_DQM_W  = 2;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } state_t;

  typedef struct packed {
    logic                  we;
    logic [REQ_ADDR_W-1:0] addr;
    logic [REQ_DATA_W-1:0] data;
    logic [REQ_DQM_W-1:0]  byte_en;
  } req_t;

endpackage

// File: rtl/sdram_port_if.sv
// One controller port: the client drives the command fields, the controller answers.
interface sdram_port_if #(
  parameter int ADDR_WIDTH   = 25,
  parameter int DATA_WIDTH   = 16,
  parameter int DQM_WIDTH    = 2,
  parameter int OUTPUT_WIDTH = 16
);
  logic [ADDR_WIDTH-1:0]   addr;
  logic [DATA_WIDTH-1:0]   data;
  logic [DQM_WIDTH-1:0]    byte_en;
  logic                    wr;
  logic                    rd;
  logic [OUTPUT_WIDTH-1:0] q;
  logic                    available;
  logic                    ready;

  modport client (output addr, data, byte_en, wr, rd, input q, available, ready);
  modport controller (input addr, data, byte_en, wr, rd, output q, available, ready);
endinterface

// File: rtl/sdram_client_fifo.sv
// Request FIFO; pointers wrap naturally because DEPTH is a power of two.
module sdram_client_fifo
  import sdram_client_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          push_i,
  input  req_t          wdata_i,
  input  logic          pop_i,
  output req_t          rdata_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  req_t          mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/sdram_port_client.sv
// Single-outstanding SDRAM port initiator with a request FIFO.
// Optional wait timeout is built when SDRAM_CLIENT_TIMEOUT_EN is defined.
module sdram_port_client
  import sdram_client_pkg::*;
#(
  parameter int ADDR_WIDTH     = REQ_ADDR_W,
  parameter int DATA_WIDTH     = REQ_DATA_W,
  parameter int DQM_WIDTH      = REQ_DQM_W,
  parameter int OUTPUT_WIDTH   = 16,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_data,
  input  logic [DQM_WIDTH-1:0]    req_byte_en,
  output logic                    rsp_valid,
  output logic                    rsp_we,
  output logic [OUTPUT_WIDTH-1:0] rsp_q,
  output logic                    rsp_error,
  output logic                    busy,
  sdram_port_if.client            port
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  state_t                  state_q, state_d;
  req_t                    push_req, head;
  logic                    full, empty, push, pop;
  logic [CW-1:0]           fifo_count;
  logic                    rsp_fire, tmo_fire, tmo_hit;
  logic                    we_q;
  logic                    rsp_valid_q, rsp_we_q;
  logic [OUTPUT_WIDTH-1:0] rsp_data_q;

  assign push_req = '{we: req_we, addr: req_addr, data: req_data, byte_en: req_byte_en};
  assign push     = req_valid && !full;

  sdram_client_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (push),
    .wdata_i (push_req),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (fifo_count)
  );

`ifdef SDRAM_CLIENT_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt_q;
  logic          rsp_error_q;

  // Fires in the last allowed WAIT cycle, as the count is about to reach TIMEOUT_CYCLES.
  assign tmo_hit = (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tmo_cnt_q   <= '0;
      rsp_error_q <= 1'b0;
    end else begin
      if (state_q == ISSUE)     tmo_cnt_q <= '0;
      else if (state_q == WAIT) tmo_cnt_q <= tmo_cnt_q + 1'b1;
      if (rsp_fire || tmo_fire) rsp_error_q <= tmo_fire;
    end
  end

  assign rsp_error = rsp_error_q;
`else
  logic unused_timeout;
  assign unused_timeout = |TIMEOUT_CYCLES;
  assign tmo_hit        = 1'b0;
  assign rsp_error      = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    pop      = 1'b0;
    rsp_fire = 1'b0;
    tmo_fire = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty && port.available) begin
          pop     = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (port.ready) begin
          rsp_fire = 1'b1;
          state_d  = IDLE;
        end else if (tmo_hit) begin
          tmo_fire = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      port.addr    <= '0;
      port.data    <= '0;
      port.byte_en <= '0;
      port.rd      <= 1'b0;
      port.wr      <= 1'b0;
      we_q         <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_we_q     <= 1'b0;
      rsp_data_q   <= '0;
    end else begin
      state_q <= state_d;
      port.rd <= pop && !head.we;
      port.wr <= pop && head.we;
      // Command fields stay latched through WAIT until the next pop.
      if (pop) begin
        port.addr    <= head.addr;
        port.data    <= head.data;
        port.byte_en <= head.byte_en;
        we_q         <= head.we;
      end
      rsp_valid_q <= rsp_fire || tmo_fire;
      if (rsp_fire) begin
        rsp_we_q   <= we_q;
        rsp_data_q <= we_q ? '0 : port.q;
      end else if (tmo_fire) begin
        rsp_we_q   <= we_q;
        rsp_data_q <= '0;
      end
    end
  end

  assign req_ready = !full;
  assign busy      = (fifo_count != '0) || (state_q != IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_we    = rsp_we_q;
  assign rsp_q     = rsp_data_q;

endmodule

// File: tb/tb_sdram_port_client.sv
// Bench for sdram_port_client: scoreboard of accepted requests plus a controller model.
module tb_sdram_port_client;

  localparam int AW = 25, DW = 16, MW = 2, OW = 16, DEPTH = 4;
`ifdef SDRAM_CLIENT_TIMEOUT_EN
  localparam int TMO = 8;
`else
  localparam int TMO = 1024;
`endif

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          req_valid = 1'b0, req_we = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_data = '0;
  logic [MW-1:0] req_byte_en = '0;
  logic          req_ready, rsp_valid, rsp_we, rsp_error, busy;
  logic [OW-1:0] rsp_q;

  sdram_port_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DQM_WIDTH(MW), .OUTPUT_WIDTH(OW)) pif ();

  sdram_port_client #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DQM_WIDTH(MW), .OUTPUT_WIDTH(OW),
    .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_data(req_data), .req_byte_en(req_byte_en),
    .rsp_valid(rsp_valid), .rsp_we(rsp_we), .rsp_q(rsp_q), .rsp_error(rsp_error),
    .busy(busy), .port(pif)
  );

  always #5 clk = ~clk;

  typedef struct {logic we; logic [AW-1:0] addr; logic [DW-1:0] data; logic [MW-1:0] be;} req_s;
  typedef struct {logic we; logic [OW-1:0] q; logic err;} rsp_s;

  req_s pushed[$];
  rsp_s exp_rsp[$];
  req_s cur;
  int   n_chk = 0, n_fail = 0;
  bit   outstanding = 0, expect_rsp = 1, noready = 0, use_fixed = 0;
  int   wcnt = 0, dly = 3;
  logic [OW-1:0] fixed_q = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Controller model and monitors, all evaluated mid-cycle.
  always @(negedge clk) begin
    rsp_s r;
    req_s e;
    pif.ready = 1'b0;
    if (reset_n) begin
      if (outstanding) begin
        if (expect_rsp) begin
          chk("hold_addr", 64'(pif.addr), 64'(cur.addr));
          chk("hold_data", 64'(pif.data), 64'(cur.data));
          chk("hold_be", 64'(pif.byte_en), 64'(cur.be));
        end
        wcnt--;
        if (wcnt <= 0) begin
          pif.ready = 1'b1;
          pif.q = use_fixed ? fixed_q : OW'($urandom);
          if (expect_rsp) begin
            r.we = cur.we; r.q = cur.we ? '0 : pif.q; r.err = 1'b0;
            exp_rsp.push_back(r);
          end
          outstanding = 0;
        end
      end
      if (pif.rd || pif.wr) begin
        chk("no_overlap", 64'(outstanding), 64'(0));
        chk("rd_wr_exclusive", 64'(pif.rd & pif.wr), 64'(0));
        chk("pulse_expected", 64'(pushed.size() != 0), 64'(1));
        if (pushed.size() != 0) begin
          e = pushed.pop_front();
          chk("issue_req", {20'd0, pif.wr, pif.addr, pif.data, pif.byte_en},
              {20'd0, e.we, e.addr, e.data, e.be});
          cur = e;
        end
        if (!noready) begin
          outstanding = 1;
          wcnt = dly;
        end
      end
      if (rsp_valid) begin
        chk("rsp_expected", 64'(exp_rsp.size() != 0), 64'(1));
        if (exp_rsp.size() != 0) begin
          r = exp_rsp.pop_front();
          chk("rsp", {rsp_we, rsp_error, rsp_q}, {r.we, r.err, r.q});
        end
      end
    end
  end

  task automatic push(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic [MW-1:0] be);
    int t = 0;
    req_s e;
    while (!req_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("push_ready_wait", 64'(req_ready), 64'(1));
    req_valid = 1'b1; req_we = we; req_addr = a; req_data = d; req_byte_en = be;
    e.we = we; e.addr = a; e.data = d; e.be = be;
    if (req_ready) pushed.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic drain(input string tag, input int max);
    int t = 0;
    while ((pushed.size() != 0 || outstanding || exp_rsp.size() != 0 || busy) && t < max) begin
      @(negedge clk);
      t++;
    end
    chk({"drain_", tag}, 64'(t < max), 64'(1));
  endtask

  task automatic wait_rsp(input int max, output int cyc);
    cyc = 0;
    while (!rsp_valid && cyc < max) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, acc, seen;
    req_s e;
    pif.available = 1'b0; pif.q = '0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'(1));
    chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rst_rsp_we", 64'(rsp_we), 64'(0));
    chk("rst_rsp_q", 64'(rsp_q), 64'(0));
    chk("rst_rsp_error", 64'(rsp_error), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_rd_wr", 64'({pif.rd, pif.wr}), 64'(0));
    chk("rst_addr", 64'(pif.addr), 64'(0));
    reset_n = 1'b1;
    @(negedge clk);

    // Directed read: ready 3 cycles after rd, rsp in cycle 6.
    pif.available = 1'b1; dly = 3; use_fixed = 1; fixed_q = 16'hBEEF;
    push(1'b0, 25'h000123, 16'h0, 2'b11);
    chk("rd_cycle1", 64'(pif.rd), 64'(0));
    @(negedge clk);
    chk("rd_cycle2", 64'(pif.rd), 64'(1));
    chk("rd_addr", 64'(pif.addr), 64'(25'h000123));
    chk("busy_active", 64'(busy), 64'(1));
    wait_rsp(40, cyc);
    chk("rd_rsp_cycle", 64'(cyc + 2), 64'(6));
    chk("rd_rsp_q", 64'(rsp_q), 64'(16'hBEEF));
    chk("rd_rsp_we", 64'(rsp_we), 64'(0));
    @(negedge clk);
    chk("rsp_one_cycle", 64'(rsp_valid), 64'(0));

    // Directed write.
    push(1'b1, 25'h000456, 16'h1234, 2'b01);
    @(negedge clk);
    chk("wr_cycle2", 64'({pif.wr, pif.rd}), 64'(2'b10));
    wait_rsp(40, cyc);
    chk("wr_rsp_cycle", 64'(cyc + 2), 64'(6));
    chk("wr_rsp", 64'({rsp_we, rsp_q}), 64'({1'b1, 16'h0}));

    // Minimum latency.
    dly = 1; use_fixed = 0;
    push(1'b0, 25'h1ABCDEF, 16'h0, 2'b10);
    @(negedge clk);
    wait_rsp(40, cyc);
    chk("min_latency", 64'(cyc + 2), 64'(4));
    drain("directed", 100);

    // Fill with controller unavailable; fifth offer must be refused.
    pif.available = 1'b0; dly = 2; acc = 0;
    for (int i = 0; i < 5; i++) begin
      req_valid = 1'b1; req_we = 1'($urandom); req_addr = AW'($urandom);
      req_data = DW'($urandom); req_byte_en = MW'($urandom);
      if (req_ready) begin
        e.we = req_we; e.addr = req_addr; e.data = req_data; e.be = req_byte_en;
        pushed.push_back(e);
        acc++;
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    chk("fill_accepts", 64'(acc), 64'(4));
    chk("fill_ready_low", 64'(req_ready), 64'(0));
    chk("fill_no_issue", 64'({pif.rd, pif.wr}), 64'(0));
    pif.available = 1'b1;
    drain("fill", 200);
    chk("fill_ready_back", 64'(req_ready), 64'(1));

    // Push and pop on the same edge keep the count.
    pif.available = 1'b0; dly = 5;
    for (int i = 0; i < 3; i++) push(1'($urandom), AW'($urandom), DW'($urandom), MW'($urandom));
    pif.available = 1'b1;
    push(1'b0, 25'h0AAAAAA, 16'h5555, 2'b11);
    chk("simul_count_3", 64'(req_ready), 64'(1));
    push(1'b1, 25'h0555555, 16'hAAAA, 2'b11);
    chk("simul_count_4", 64'(req_ready), 64'(0));
    drain("simul", 300);

    // Randomized traffic.
    for (int i = 0; i < 40; i++) begin
      dly = $urandom_range(1, 6);
      pif.available = req_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      push(1'($urandom), AW'($urandom), DW'($urandom), MW'($urandom));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    pif.available = 1'b1;
    drain("random", 2000);

    // Reset while waiting with two entries queued.
    dly = 30;
    for (int i = 0; i < 3; i++) push(1'b0, AW'(i + 16), DW'(0), 2'b11);
    cyc = 0;
    while (!outstanding && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("flush_reached_wait", 64'(outstanding), 64'(1));
    expect_rsp = 0;
    reset_n = 1'b0;
    @(negedge clk);
    chk("flush_rd_wr", 64'({pif.rd, pif.wr}), 64'(0));
    chk("flush_busy", 64'(busy), 64'(0));
    chk("flush_ready", 64'(req_ready), 64'(1));
    reset_n = 1'b1;
    pushed.delete();
    exp_rsp.delete();
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    chk("flush_no_rsp", 64'(seen), 64'(0));
    outstanding = 0;
    expect_rsp = 1;

`ifdef SDRAM_CLIENT_TIMEOUT_EN
    // Timeout: no ready ever; response after 8 WAIT cycles.
    noready = 1;
    push(1'b0, 25'h0000777, 16'h0, 2'b11);
    @(negedge clk);
    chk("tmo_pulse", 64'(pif.rd), 64'(1));
    e.we = 1'b0;
    exp_rsp.push_back('{we: 1'b0, q: '0, err: 1'b1});
    wait_rsp(40, cyc);
    chk("tmo_latency", 64'(cyc), 64'(9));
    chk("tmo_rsp", 64'({rsp_valid, rsp_error, rsp_we, rsp_q}), 64'({1'b1, 1'b1, 1'b0, 16'h0}));
    noready = 0;
    expect_rsp = 0; outstanding = 1; wcnt = 3;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    chk("tmo_stray_ready", 64'(seen), 64'(0));
    outstanding = 0;
    expect_rsp = 1;
`endif

    // Normal operation after flush.
    dly = 2;
    push(1'b0, 25'h0000042, 16'h0, 2'b11);
    drain("post_reset", 100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
